// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// The state selector below is used both at accept time and when the quad phase ends.
package shift_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;
   localparam int QUAD_W  = SHAMT_W - 2;

   localparam logic DIR_LLS = 1'b0;
   localparam logic DIR_RAS = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT4 = 2'd1,
      SHIFT1 = 2'd2,
      DONE   = 2'd3
   } state_t;

   // First phase that still has work to do, given the remaining quad and single counts.
   function automatic state_t pick_state(input logic [QUAD_W-1:0] quads,
                                         input logic [1:0]        singles);
      if (quads != '0) begin
         return SHIFT4;
      end else if (singles != '0) begin
         return SHIFT1;
      end else begin
         return DONE;
      end
   endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step, either by 4 or by 1 bit.
// Left-logical steps fill with zeros; right-arithmetic steps replicate bit 31.
module shift_step
   import shift_pkg::*;
(
   input  logic [WIDTH-1:0] value,
   input  logic             by4,
   input  logic             dir,
   output logic [WIDTH-1:0] result
);

   function automatic logic [WIDTH-1:0] lls(input logic [WIDTH-1:0] v, input logic four);
      if (four) begin
         return {v[WIDTH-5:0], 4'b0000};
      end else begin
         return {v[WIDTH-2:0], 1'b0};
      end
   endfunction

   function automatic logic [WIDTH-1:0] ras(input logic [WIDTH-1:0] v, input logic four);
      if (four) begin
         return {{4{v[WIDTH-1]}}, v[WIDTH-1:4]};
      end else begin
         return {v[WIDTH-1], v[WIDTH-1:1]};
      end
   endfunction

   always_comb begin
      result = (dir == DIR_RAS) ? ras(value, by4) : lls(value, by4);
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 0-31 bit shifter: a shamt is split into quad steps then single steps,
// all executed by one shared shift_step instance, with valid/ready on both sides.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_dir,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   state_t              state, state_nxt;
   logic [QUAD_W-1:0]   q, q_nxt;
   logic [1:0]          s, s_nxt;
   logic [WIDTH-1:0]    work, work_nxt;
   logic                dir, dir_nxt;
   logic                by4;
   logic [WIDTH-1:0]    step_res;

   assign by4 = (state == SHIFT4);

   shift_step u_step (
      .value  (work),
      .by4    (by4),
      .dir    (dir),
      .result (step_res)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         q     <= '0;
         s     <= '0;
         work  <= '0;
         dir   <= DIR_LLS;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
         s     <= s_nxt;
         work  <= work_nxt;
         dir   <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      s_nxt     = s;
      work_nxt  = work;
      dir_nxt   = dir;
      case (state)
         IDLE: begin
            if (in_valid) begin
               work_nxt  = in_data;
               dir_nxt   = in_dir;
               q_nxt     = in_shamt[SHAMT_W-1:2];
               s_nxt     = in_shamt[1:0];
               state_nxt = pick_state(in_shamt[SHAMT_W-1:2], in_shamt[1:0]);
            end
         end
         SHIFT4: begin
            work_nxt = step_res;
            q_nxt    = q - QUAD_W'(1);
            if (q == QUAD_W'(1)) begin
               state_nxt = pick_state('0, s);
            end
         end
         SHIFT1: begin
            work_nxt = step_res;
            s_nxt    = s - 2'd1;
            if (s == 2'd1) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            // New requests wait until the result has been taken; no same-cycle turnaround.
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results are queued on accept and
// compared when out_valid rises, along with latency and handshake behaviour.
module tb_shift_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_dir;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   typedef struct {
      logic [31:0] data;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   shift_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   function automatic exp_t model(input logic [31:0] d, input logic [4:0] sh, input logic dr);
      exp_t e;
      logic signed [31:0] sd;
      sd = d;
      if (dr) e.data = sd >>> sh;
      else    e.data = d << sh;
      e.lat = 1 + int'(sh[4:2]) + int'(sh[1:0]);
      return e;
   endfunction

   // Present a request for one edge; caller guarantees the block is idle.
   task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic dr);
      sb.push_back(model(d, sh, dr));
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = sh;
      in_dir   = dr;
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_dir   = 1'($urandom);
   endtask

   // Count edges from the accept edge until out_valid is seen (bounded).
   task automatic wait_done(output int cyc, output bit ready_seen);
      cyc = 1;
      ready_seen = 1'b0;
      while (!out_valid && cyc < 40) begin
         if (in_ready) ready_seen = 1'b1;
         @(posedge clock); #1;
         cyc++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'($urandom);
         in_data   = $urandom;
         in_shamt  = 5'($urandom);
         in_dir    = 1'($urandom);
         out_ready = 1'($urandom);
         @(posedge clock); #1;
         n_checks++;
         if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_data=%h in_ready=%b, want 0/00000000/1",
                     out_valid, out_data, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset_n   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         n_checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
         end
      end
   endtask

   // One complete operation with every result/latency/handshake comparison inline.
   task automatic test_op(input string name, input logic [31:0] d, input logic [4:0] sh,
                          input logic dr);
      int   cyc;
      bit   rdy;
      exp_t e;
      send(d, sh, dr);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_ready_drop: in_ready=%b, want 0", name, in_ready);
      end
      wait_done(cyc, rdy);
      e = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: out_valid=%b after %0d cycles, want 1", name, out_valid, cyc);
      end
      n_checks++;
      if (out_data !== e.data) begin
         n_fail++;
         $display("FAIL %s_data: got %h, want %h", name, out_data, e.data);
      end
      n_checks++;
      if (cyc !== e.lat) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d, want %0d", name, cyc, e.lat);
      end
      n_checks++;
      if (rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy_ready: in_ready seen %b during shift, want 0", name, rdy);
      end
      take();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_release: out_valid=%b in_ready=%b, want 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      int          cyc;
      bit          rdy;
      exp_t        e;
      logic [31:0] held;
      send(32'hA5A5_0001, 5'd3, 1'b0);
      wait_done(cyc, rdy);
      e = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e.data) begin
         n_fail++;
         $display("FAIL bp_first: valid=%b data=%h, want 1/%h", out_valid, out_data, e.data);
      end
      held = out_data;
      sb.push_back(model(32'h8000_00F0, 5'd4, 1'b1));
      in_valid = 1'b1;
      in_data  = 32'h8000_00F0;
      in_shamt = 5'd4;
      in_dir   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h in_ready=%b, want 1/%h/0",
                     out_valid, out_data, in_ready, held);
         end
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
      end
      wait_done(cyc, rdy);
      e = sb.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || cyc !== e.lat) begin
         n_fail++;
         $display("FAIL bp_second: valid=%b data=%h lat=%0d, want 1/%h/%0d",
                  out_valid, out_data, cyc, e.data, e.lat);
      end
      take();
   endtask

   task automatic test_reset_mid();
      send(32'h0000_FFFF, 5'd20, 1'b0);
      @(posedge clock); #1;
      @(posedge clock); #3;
      reset_n = 1'b0;
      #2;
      void'(sb.pop_back());
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_async: valid=%b data=%h in_ready=%b, want 0/00000000/1",
                  out_valid, out_data, in_ready);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clock); #1;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_spurious: out_valid=%b at cycle %0d, want 0", out_valid, i);
         end
      end
      test_op("after_reset", 32'h0000_0003, 5'd2, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         test_op("random", $urandom, 5'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_dir    = 1'b0;
      out_ready = 1'b0;
      #1;
      test_reset();
      test_op("lls5", 32'h0000_0001, 5'd5, 1'b0);
      test_op("ras31", 32'h8000_0000, 5'd31, 1'b1);
      test_op("ras8", 32'hF000_000F, 5'd8, 1'b1);
      test_op("zero", 32'h1234_5678, 5'd0, 1'b0);
      test_op("lls31", 32'hFFFF_FFFF, 5'd31, 1'b0);
      test_op("ras_pos", 32'h7000_0000, 5'd30, 1'b1);
      test_backpressure();
      test_reset_mid();
      test_random();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
